branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Resolution side of the PC prediction loop. Records each fetched PC and its predicted next PC
//  in an in-order queue. At EX, pops the oldest entry and compares it against the actual next PC.
//  On a mismatch, issues a one-cycle flush/redirect to fetch.
//  For every control-flow instruction, issues a registered update (pc, taken, target) to the
//  BTB/BHT predictor.
// PARAMETERS
//  DEPTH  4   in-flight prediction entries; power of two, >=2
//  PTR_W  2   log2(DEPTH)
//  XLEN   32  address width
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     reset, synchronous, active-high
//  push_valid      in   1     fetch delivers an instruction this cycle
//  push_ready      out  1     queue can accept (~full | pop this cycle)
//  push_pc         in   XLEN  fetched PC
//  push_pred_pc    in   XLEN  predicted next PC from predictor
//  ex_valid        in   1     instruction in EX completes this cycle (pops head)
//  ex_is_cf        in   1     EX instruction is branch/jump
//  ex_taken        in   1     actual direction (ignored unless ex_is_cf)
//  ex_target       in   XLEN  actual taken target
//  redirect_valid  out  1     flush younger instructions, refetch from redirect_pc
//  redirect_pc     out  XLEN  correct next PC
//  upd_valid       out  1     predictor update strobe
//  upd_pc          out  XLEN  PC of resolved control-flow instruction
//  upd_taken       out  1     actual outcome
//  upd_target      out  XLEN  actual target
//  err_underflow   out  1     sticky: ex_valid seen while queue empty
// BEHAVIOUR
//  - Reset: queue empty, pointers 0. All outputs 0, except push_ready=1.
//  - Queue: FIFO, wr_ptr/rd_ptr PTR_W bits plus a wrap bit.
//    empty = ptrs equal; full = same index, wrap bits differ.
//  - Push accepted when push_valid & push_ready. Push while full without a same-cycle pop
//    is dropped; push_ready=0 forbids it.
//  - Simultaneous push+pop: legal, including when full or empty.
//    Pop while empty with push in the same cycle is NOT a bypass: counts as underflow,
//    and the push is still written.
//  - Resolve (combinational on head):
//    actual = (ex_is_cf & ex_taken) ? ex_target : head_pc + 4, mod 2^XLEN wrap.
//    mispredict = ex_valid & ~empty & (actual != head_pred_pc).
//  - Outputs registered, 1-cycle latency. In cycle N+1 after a resolving pop in cycle N:
//    - redirect_valid = mispredict(N), redirect_pc = actual(N)
//    - upd_valid = ex_is_cf(N) & ex_valid & ~empty; upd_pc = head_pc; upd_taken; upd_target
//    Each is a 1-cycle pulse.
//  - Flush: the cycle redirect_valid=1 also clears the queue (wr_ptr<=rd_ptr) at its end.
//    All pushes and pops in that cycle are discarded: they belong to the wrong path.
//    No second redirect can be generated from the discarded entries.
//  - Non-CF mismatch (pred != pc+4 on non-branch, e.g. stale BTB alias):
//    still a mispredict, redirect to pc+4, upd_valid=0.
//  - Reset mid-operation: immediate empty queue; pending redirect/upd pulses cancelled.
// CONFIGURATION
//  BRANCH_RESOLVE_STATS_EN defined: adds outputs
//    stat_cf_cnt[31:0]  resolved control-flow instructions
//    stat_mis_cnt[31:0] mispredicts (including non-CF)
//  Both counters are free-running, wrap at 2^32, and clear on reset.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Shared package/header (bp_pkg.vh): XLEN, BP_DEPTH, BP_PTR_W,
//    `define BP_INSN_BYTES 4, and the entry layout {pc, pred_pc}.
//  One natural sub-module: bp_pred_queue (parameterised FIFO with flush input).
//  This module holds compare, redirect/update registers, and stats.
// TESTING
//  1 Push pc=0x100 pred=0x104; ex_valid, ex_is_cf=0 -> no redirect, no upd, queue empty.
//  2 Push pc=0x200 pred=0x204; ex_valid, cf=1, taken=1, target=0x300 ->
//    next cycle redirect_valid=1 pc=0x300; upd pc=0x200 taken=1 target=0x300;
//    queue empty after.
//  3 Push pc=0x40 pred=0x80; cf=1, taken=1, target=0x80 ->
//    upd_valid=1, redirect_valid=0.
//  4 Push 4 entries without pop -> push_ready=0.
//    Push+pop in the same cycle -> accepted; count stays 4.
//  5 Mispredict with 3 younger entries queued + push in the redirect cycle ->
//    queue empty after; next pop raises err_underflow=1, sticky until reset.
//  6 pc=0xFFFFFFFC pred=0x0, not taken -> actual wraps to 0x0, no redirect.
//    Reset asserted the cycle after a mispredict pop -> redirect_valid stays 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution slice: default sizes,
// instruction width and the prediction queue entry layout.
package branch_resolve_unit_pkg;

  localparam int BP_XLEN       = 32;
  localparam int BP_DEPTH      = 4;
  localparam int BP_PTR_W      = 2;
  localparam int BP_INSN_BYTES = 4;

  // One in-flight prediction: fetched PC and the next PC the predictor chose.
  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic [BP_XLEN-1:0] pred_pc;
  } bp_entry_t;

  localparam int BP_ENTRY_W = $bits(bp_entry_t);

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order prediction queue: power-of-two FIFO with wrap-bit pointers and a
// flush input that drops every stored entry (and any same-cycle push/pop).
module branch_resolve_unit_pred_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = BP_PTR_W,
  parameter int W     = BP_ENTRY_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head_data
);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [W-1:0]   mem [DEPTH];
  logic           pop_ok;
  logic           push_ok;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                     (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign head_data = mem[rd_ptr[PTR_W-1:0]];
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);

  // Pointer update; a flush collapses the queue onto the read pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; wrong-path writes during a flush are not kept.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: compares the oldest queued prediction against the
// real next PC at EX, raises a one-cycle redirect on mismatch and sends a
// registered update to the predictor for every control-flow instruction.
// Optional statistics counters are enabled by BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = BP_PTR_W,
  parameter int XLEN  = BP_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_pred_pc,
  input  logic            ex_valid,
  input  logic            ex_is_cf,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_target,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]     stat_cf_cnt,
  output logic [31:0]     stat_mis_cnt,
`endif
  output logic            err_underflow
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_pc;
  } entry_t;

  entry_t          head;
  logic            q_empty;
  logic            q_full;
  logic            flush;
  logic            resolve;
  logic            mispredict;
  logic            upd_fire;
  logic            underflow;
  logic [XLEN-1:0] actual;
  logic            redirect_q;
  logic            upd_q;

  assign push_ready = ~q_full | ex_valid;

  // Pending pulses are cancelled as soon as reset is seen, not one edge later.
  assign redirect_valid = redirect_q & ~reset;
  assign upd_valid      = upd_q & ~reset;

  // The redirect cycle is wrong-path: nothing popped then may resolve.
  assign flush      = redirect_valid;
  assign resolve    = ex_valid & ~q_empty & ~flush;
  assign underflow  = ex_valid & q_empty & ~flush;
  assign actual     = (ex_is_cf && ex_taken) ? ex_target
                                             : head.pc + XLEN'(BP_INSN_BYTES);
  assign mispredict = resolve & (actual != head.pred_pc);
  assign upd_fire   = resolve & ex_is_cf;

  branch_resolve_unit_pred_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (2*XLEN)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push_valid & push_ready),
    .pop       (ex_valid),
    .push_data ({push_pc, push_pred_pc}),
    .empty     (q_empty),
    .full      (q_full),
    .head_data (head)
  );

  // Registered redirect/update pulses and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_q    <= 1'b0;
      redirect_pc   <= '0;
      upd_q         <= 1'b0;
      upd_pc        <= '0;
      upd_taken     <= 1'b0;
      upd_target    <= '0;
      err_underflow <= 1'b0;
    end else begin
      redirect_q    <= mispredict;
      upd_q         <= upd_fire;
      err_underflow <= err_underflow | underflow;
      if (mispredict) redirect_pc <= actual;
      if (upd_fire) begin
        upd_pc     <= head.pc;
        upd_taken  <= ex_taken;
        upd_target <= ex_target;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Free-running resolution statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cf_cnt  <= '0;
      stat_mis_cnt <= '0;
    end else begin
      if (upd_fire)   stat_cf_cnt  <= stat_cf_cnt + 32'd1;
      if (mispredict) stat_mis_cnt <= stat_mis_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a behavioural queue model and
// a scoreboard of expected registered outputs.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_pred_pc;
  logic        ex_valid;
  logic        ex_is_cf;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        err_underflow;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  exp_t sb[$];
  ent_t mq[$];
  bit   m_flush;
  bit   m_err;
  int   total = 0;
  int   bad   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk            (clk),
    .reset          (reset),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_pc        (push_pc),
    .push_pred_pc   (push_pred_pc),
    .ex_valid       (ex_valid),
    .ex_is_cf       (ex_is_cf),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .err_underflow  (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
    if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
    chk("upd_valid", 32'(upd_valid), 32'(e.uv));
    if (e.uv) begin
      chk("upd_pc", upd_pc, e.upc);
      chk("upd_taken", 32'(upd_taken), 32'(e.ut));
      chk("upd_target", upd_target, e.utg);
    end
    chk("err_underflow", 32'(err_underflow), 32'(e.err));
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic [31:0] pp,
                               input logic ev, input logic cf, input logic tk,
                               input logic [31:0] tgt);
    exp_t        e;
    logic        rdy;
    logic [31:0] act;
    e = '{default: '0};
    push_valid   = pv;
    push_pc      = ppc;
    push_pred_pc = pp;
    ex_valid     = ev;
    ex_is_cf     = cf;
    ex_taken     = tk;
    ex_target    = tgt;
    rdy = (mq.size() < 4) || ev;
    #1;
    chk("push_ready", 32'(push_ready), 32'(rdy));
    if (m_flush) begin
      mq.delete();
      m_flush = 1'b0;
    end else begin
      if (ev && mq.size() == 0) m_err = 1'b1;
      if (ev && mq.size() > 0) begin
        act = (cf && tk) ? tgt : mq[0].pc + 32'd4;
        e.rv  = (act != mq[0].pred);
        e.rpc = act;
        e.uv  = cf;
        e.upc = mq[0].pc;
        e.ut  = tk;
        e.utg = tgt;
        m_flush = e.rv;
        void'(mq.pop_front());
      end
      if (pv && rdy) mq.push_back('{ppc, pp});
    end
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic doReset();
    reset      = 1'b1;
    push_valid = 1'b0;
    ex_valid   = 1'b0;
    ex_is_cf   = 1'b0;
    ex_taken   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    sb.delete();
    m_flush = 1'b0;
    m_err   = 1'b0;
    #1;
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_err_underflow", 32'(err_underflow), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    reset        = 1'b1;
    push_valid   = 1'b0;
    push_pc      = '0;
    push_pred_pc = '0;
    ex_valid     = 1'b0;
    ex_is_cf     = 1'b0;
    ex_taken     = 1'b0;
    ex_target    = '0;
    m_flush      = 1'b0;
    m_err        = 1'b0;
    repeat (2) @(posedge clk);
    doReset();

    // Correctly predicted sequential instruction.
    applyStimulus(1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();

    // Taken branch predicted not-taken: redirect to 0x300.
    applyStimulus(1'b1, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300);
    chk("t2_redirect_pc", redirect_pc, 32'h300);
    chk("t2_upd_pc", upd_pc, 32'h200);
    idle();

    // Taken branch predicted correctly: update only.
    applyStimulus(1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80);
    idle();

    // Fill to capacity, then push+pop while full.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h1000 + 32'(i*16), 32'h1004 + 32'(i*16), 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h3000, 32'h3004, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h4000, 32'h4004, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Mispredict with three younger wrong-path entries and a push/pop in the flush cycle.
    applyStimulus(1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i < 4; i++)
      applyStimulus(1'b1, 32'h500 + 32'(i*16), 32'h999, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_redirect_pc", redirect_pc, 32'h504);
    applyStimulus(1'b1, 32'h700, 32'h704, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_err_set", 32'(err_underflow), 32'd1);
    idle();
    idle();

    // Reset clears the sticky error.
    doReset();

    // Address wrap on the sequential path, not-taken branch.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1234);
    idle();

    // Reset right after a mispredicting pop cancels the redirect pulse.
    applyStimulus(1'b1, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    push_valid = 1'b0;
    ex_valid   = 1'b1;
    ex_is_cf   = 1'b0;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("t6_rst_redirect", 32'(redirect_valid), 32'd0);
    chk("t6_rst_upd", 32'(upd_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_after_redirect", 32'(redirect_valid), 32'd0);
    chk("t6_after_ready", 32'(push_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
